// File: rtl/shamt_shift_unit.sv
// rtl/shamt_shift_unit.sv - multi-cycle SLL/SRL/SRA/ROL/ROR shift unit with selectable amount source
// Define SHAMT_SHIFT_FAST_EN for the single-pass barrel-shift build.
module shamt_shift_unit #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int N_SRC   = 3,
    parameter int SEL_W   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [2:0]                 op,
    input  logic [SEL_W-1:0]           amt_sel,
    input  logic [N_SRC*SHAMT_W-1:0]   amt_srcs,
    input  logic [DATA_W-1:0]          data_in,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [DATA_W-1:0]          data_out
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state;
    state_t             next_state;
    logic [SHAMT_W-1:0] sel_amt;
    logic               legal;
    logic               err_q;

    always_comb begin
        sel_amt = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (amt_sel == SEL_W'(k)) begin
                sel_amt = amt_srcs[k*SHAMT_W +: SHAMT_W];
            end
        end
    end

    // The extra bit keeps the bound exact when N_SRC == 2^SEL_W.
    assign legal = (op <= 3'd4) && ({1'b0, amt_sel} < (SEL_W+1)'(N_SRC));

    assign busy = (state == SHIFT);
    assign done = (state == DONE);
    assign err  = done & err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

`ifdef SHAMT_SHIFT_FAST_EN

    function automatic logic [DATA_W-1:0] barrel(input logic [2:0] o,
                                                  input logic [DATA_W-1:0] d,
                                                  input logic [SHAMT_W-1:0] a);
        logic [31:0] r;
        logic [DATA_W-1:0] res;
        r   = 32'(a) % 32'(DATA_W);
        res = d;
        case (o)
            3'd0:    res = d << a;
            3'd1:    res = d >> a;
            3'd2:    res = $signed(d) >>> a;
            3'd3:    res = (d << r) | (d >> (32'(DATA_W) - r));
            3'd4:    res = (d >> r) | (d << (32'(DATA_W) - r));
            default: res = d;
        endcase
        return res;
    endfunction

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = DONE;
            SHIFT:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
            err_q    <= 1'b0;
        end else if (state == IDLE && start) begin
            err_q    <= !legal;
            data_out <= legal ? barrel(op, data_in, sel_amt) : '0;
        end
    end

`else

    logic [DATA_W-1:0]  work;
    logic [2:0]         cur_op;
    logic [SHAMT_W-1:0] count;

    function automatic logic [DATA_W-1:0] step(input logic [2:0] o,
                                                input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] res;
        case (o)
            3'd0:    res = {d[DATA_W-2:0], 1'b0};
            3'd1:    res = {1'b0, d[DATA_W-1:1]};
            3'd2:    res = {d[DATA_W-1], d[DATA_W-1:1]};
            3'd3:    res = {d[DATA_W-2:0], d[DATA_W-1]};
            3'd4:    res = {d[0], d[DATA_W-1:1]};
            default: res = d;
        endcase
        return res;
    endfunction

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (!legal || sel_amt == '0) next_state = DONE;
                    else                         next_state = SHIFT;
                end
            end
            SHIFT:   if (count == SHAMT_W'(1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // data_out is loaded on the edge entering DONE so it is valid alongside done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work     <= '0;
            cur_op   <= '0;
            count    <= '0;
            err_q    <= 1'b0;
            data_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work   <= data_in;
                        cur_op <= op;
                        count  <= legal ? sel_amt : '0;
                        err_q  <= !legal;
                        if (!legal)               data_out <= '0;
                        else if (sel_amt == '0)   data_out <= data_in;
                    end
                end
                SHIFT: begin
                    work  <= step(cur_op, work);
                    count <= count - SHAMT_W'(1);
                    if (count == SHAMT_W'(1)) data_out <= step(cur_op, work);
                end
                default: ;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_shamt_shift_unit.sv
// tb/tb_shamt_shift_unit.sv - vector-table and scoreboard bench for shamt_shift_unit
module tb_shamt_shift_unit;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    localparam int N_SRC   = 3;
    localparam int SEL_W   = 2;
`ifdef SHAMT_SHIFT_FAST_EN
    localparam int FAST = 1;
`else
    localparam int FAST = 0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [1:0]  amt_sel;
    logic [14:0] amt_srcs;
    logic [31:0] data_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] data_out;

    shamt_shift_unit #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W), .N_SRC(N_SRC), .SEL_W(SEL_W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .amt_sel(amt_sel),
        .amt_srcs(amt_srcs), .data_in(data_in), .busy(busy), .done(done),
        .err(err), .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  sel;
        logic [14:0] srcs;
        logic [31:0] data;
        int          amt;
        logic [31:0] exp_out;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] out;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input int a, input logic [31:0] d);
        int r;
        r = a % 32;
        case (o)
            3'd0: return (a >= 32) ? 32'h0 : d << a;
            3'd1: return (a >= 32) ? 32'h0 : d >> a;
            3'd2: return (a >= 32) ? {32{d[31]}} : 32'($signed(d) >>> a);
            3'd3: return (r == 0) ? d : ((d << r) | (d >> (32 - r)));
            3'd4: return (r == 0) ? d : ((d >> r) | (d << (32 - r)));
            default: return 32'h0;
        endcase
    endfunction

    function automatic vec_t mk(input logic [2:0] o, input logic [1:0] s,
                                input logic [4:0] s2, input logic [4:0] s1, input logic [4:0] s0,
                                input logic [31:0] d, input logic [31:0] eo, input logic ee);
        vec_t v;
        v.op = o; v.sel = s; v.srcs = {s2, s1, s0}; v.data = d;
        v.amt = (s == 2'd0) ? int'(s0) : (s == 2'd1) ? int'(s1) : (s == 2'd2) ? int'(s2) : 0;
        v.exp_out = eo; v.exp_err = ee;
        return v;
    endfunction

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got done=1 expected no done");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_data_out", data_out, e.out);
                    chk("sb_err", 32'(err), 32'(e.err));
                end
            end else if (err) begin
                total++; bad++;
                $display("FAIL err_without_done: got err=1 expected 0");
            end
        end
    end

    task automatic wait_done(output int lat, output int bsy);
        lat = 1; bsy = 0;
        while (!done && lat < 100) begin
            if (busy) bsy++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int lat, bsy;
        exp_t e;
        @(negedge clk);
        op = v.op; amt_sel = v.sel; amt_srcs = v.srcs; data_in = v.data; start = 1'b1;
        e.out = v.exp_out; e.err = v.exp_err;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        data_in = $urandom; amt_srcs = 15'($urandom); op = 3'($urandom_range(0, 4));
        wait_done(lat, bsy);
        chk({nm, "_latency"}, 32'(lat), (v.exp_err || FAST == 1) ? 32'd1 : 32'(v.amt + 1));
        chk({nm, "_busy_cycles"}, 32'(bsy), (v.exp_err || FAST == 1) ? 32'd0 : 32'(v.amt));
        @(negedge clk);
        chk({nm, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    vec_t vecs[12];

    initial begin
        int lat, bsy, base;
        exp_t e;
        reset = 1'b1; start = 1'b0; op = '0; amt_sel = '0; amt_srcs = '0; data_in = '0;

        vecs[0]  = mk(3'd0, 2'd0, 5'd0, 5'd0, 5'd4, 32'h0000_0001, 32'h0000_0010, 1'b0);
        vecs[1]  = mk(3'd2, 2'd2, 5'd31, 5'd0, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        vecs[2]  = mk(3'd4, 2'd1, 5'd0, 5'd1, 5'd9, 32'h0000_0003, 32'h8000_0001, 1'b0);
        vecs[3]  = mk(3'd1, 2'd0, 5'd7, 5'd7, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        vecs[4]  = mk(3'd6, 2'd0, 5'd0, 5'd0, 5'd4, 32'h1234_5678, 32'h0000_0000, 1'b1);
        vecs[5]  = mk(3'd0, 2'd3, 5'd1, 5'd1, 5'd1, 32'h1234_5678, 32'h0000_0000, 1'b1);
        vecs[6]  = mk(3'd3, 2'd1, 5'd0, 5'd8, 5'd0, 32'h1234_5678, 32'h3456_7812, 1'b0);
        vecs[7]  = mk(3'd1, 2'd2, 5'd31, 5'd0, 5'd0, 32'h8000_0000, 32'h0000_0001, 1'b0);
        vecs[8]  = mk(3'd2, 2'd0, 5'd0, 5'd0, 5'd3, 32'h4000_0000, 32'h0800_0000, 1'b0);
        vecs[9]  = mk(3'd3, 2'd0, 5'd0, 5'd0, 5'd31, 32'h0000_0001, 32'h8000_0000, 1'b0);
        vecs[10] = mk(3'd5, 2'd1, 5'd0, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        vecs[11] = mk(3'd4, 2'd2, 5'd13, 5'd0, 5'd0, 32'hA5C3_0F96, model(3'd4, 13, 32'hA5C3_0F96), 1'b0);

        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_data_out", data_out, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

`ifndef SHAMT_SHIFT_FAST_EN
        // Reset in the middle of a 20-step SLL.
        @(negedge clk);
        op = 3'd0; amt_sel = 2'd0; amt_srcs = {5'd0, 5'd0, 5'd20}; data_in = 32'h1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("midreset_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_err", 32'(err), 32'd0);
        chk("midreset_data_out", data_out, 32'd0);
        base = done_cnt;
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("midreset_no_done", 32'(done_cnt - base), 32'd0);
        chk("midreset_data_held", data_out, 32'd0);
        run_vec(vecs[0], "post_reset");
`endif

        // A second start while busy must be ignored.
        base = done_cnt;
        @(negedge clk);
        op = 3'd0; amt_sel = 2'd1; amt_srcs = {5'd0, 5'd6, 5'd0}; data_in = 32'h3; start = 1'b1;
        e.out = model(3'd0, 6, 32'h3); e.err = 1'b0;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        op = 3'd4; amt_srcs = {5'd9, 5'd9, 5'd9}; data_in = 32'hFFFF_0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bsy);
        repeat (15) @(negedge clk);
        chk("busy_restart_single_done", 32'(done_cnt - base), 32'd1);
        chk("busy_restart_data_out", data_out, 32'h0000_00C0);

        // A start in the done cycle must be ignored.
        base = done_cnt;
        @(negedge clk);
        op = 3'd1; amt_sel = 2'd0; amt_srcs = {5'd0, 5'd0, 5'd2}; data_in = 32'h100; start = 1'b1;
        e.out = 32'h40; e.err = 1'b0;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bsy);
        op = 3'd0; amt_srcs = {5'd0, 5'd0, 5'd3}; data_in = 32'h5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_cycle_start_busy", 32'(busy), 32'd0);
        chk("done_cycle_start_done", 32'(done), 32'd0);
        repeat (10) @(negedge clk);
        chk("done_cycle_start_single_done", 32'(done_cnt - base), 32'd1);
        chk("done_cycle_start_data_out", data_out, 32'h40);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
